trace_collector: RTL and testbench

TRACE_COLLECTOR -- requirements
Module: trace_collector

---
 rtl/trace_collector_pkg.sv | 27 ++
 rtl/trace_collector_fifo.sv | 45 ++++
 rtl/trace_collector.sv | 92 +++++++++
 tb/tb_trace_collector.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/trace_collector_pkg.sv
// Shared types for the CPU trace collector: the queued event record and the
// store-merge helper used to form MEM events.
package trace_collector_pkg;

   localparam logic KIND_GRF = 1'b0;
   localparam logic KIND_MEM = 1'b1;

   // 129-bit record: kind + pc + dest + data + timestamp
   typedef struct packed {
      logic        kind;
      logic [31:0] pc;
      logic [31:0] dest;
      logic [31:0] data;
      logic [31:0] tstamp;
   } trace_entry_t;

   function automatic logic [31:0] merge_store(input logic [3:0]  byteen,
                                               input logic [31:0] wdata,
                                               input logic [31:0] rdata);
      logic [31:0] r;
      r = rdata;
      for (int i = 0; i < 4; i++)
         if (byteen[i]) r[8*i +: 8] = wdata[8*i +: 8];
      return r;
   endfunction

endpackage

// File: rtl/trace_collector_fifo.sv
// Trace entry storage: two write ports filled in order (port 0 then port 1),
// one read port presenting the head entry.
module trace_fifo
   import trace_collector_pkg::*;
#(
   parameter int DEPTH = 8,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [1:0]   wr_cnt,
   input  trace_entry_t wr_data0,
   input  trace_entry_t wr_data1,
   input  logic         rd_en,
   output trace_entry_t head,
   output logic [CW-1:0] count
);

   trace_entry_t  mem [DEPTH];
   logic [PW-1:0] wptr, rptr;
   logic          rd;

   // Caller guarantees wr_cnt never exceeds free space
   assign rd   = rd_en && (count != '0);
   assign head = mem[rptr];

   always_ff @(posedge clk) begin
      if (wr_cnt != 2'd0) mem[wptr] <= wr_data0;
      if (wr_cnt == 2'd2) mem[wptr + PW'(1)] <= wr_data1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         wptr  <= wptr + PW'(wr_cnt);
         rptr  <= rptr + PW'(rd);
         count <= count + CW'(wr_cnt) - CW'(rd);
      end
   end

endmodule

// File: rtl/trace_collector.sv
// Collects CPU register-write and store events into a timestamped FIFO stream,
// dropping (and counting) events that do not fit.
module trace_collector
   import trace_collector_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        w_grf_we,
   input  logic [4:0]  w_grf_addr,
   input  logic [31:0] w_grf_wdata,
   input  logic [31:0] w_inst_addr,
   input  logic [3:0]  m_data_byteen,
   input  logic [31:0] m_data_addr,
   input  logic [31:0] m_data_wdata,
   input  logic [31:0] m_data_rdata,
   input  logic [31:0] m_inst_addr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_kind,
   output logic [31:0] out_pc,
   output logic [31:0] out_dest,
   output logic [31:0] out_data,
   output logic [31:0] out_time,
   output logic        overflow,
   output logic [15:0] drop_cnt
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [31:0]   cycle;
   logic          grf_ev, mem_ev, deq;
   logic [1:0]    n_ev, n_acc, n_drop, wr_cnt;
   logic [CW:0]   free;
   logic [CW-1:0] fifo_count;
   logic [16:0]   drop_sum;
   trace_entry_t  grf_e, mem_e, wr0, head, out_e;

   assign grf_ev = w_grf_we && (w_grf_addr != 5'd0);
   assign mem_ev = |m_data_byteen;

   assign grf_e = '{kind: KIND_GRF, pc: w_inst_addr, dest: {27'd0, w_grf_addr},
                    data: w_grf_wdata, tstamp: cycle};
   assign mem_e = '{kind: KIND_MEM, pc: m_inst_addr, dest: {m_data_addr[31:2], 2'b00},
                    data: merge_store(m_data_byteen, m_data_wdata, m_data_rdata),
                    tstamp: cycle};

   // Older W-stage event takes port 0; a lone store moves down to port 0
   assign wr0 = grf_ev ? grf_e : mem_e;

   assign deq    = out_valid && out_ready;
   assign free   = (CW+1)'(DEPTH) - {1'b0, fifo_count} + (CW+1)'(deq);
   assign n_ev   = {1'b0, grf_ev} + {1'b0, mem_ev};
   assign n_acc  = (free < (CW+1)'(n_ev)) ? free[1:0] : n_ev;
   assign n_drop = n_ev - n_acc;
   assign wr_cnt = reset ? 2'd0 : n_acc;

   trace_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .wr_cnt   (wr_cnt),
      .wr_data0 (wr0),
      .wr_data1 (mem_e),
      .rd_en    (deq),
      .head     (head),
      .count    (fifo_count)
   );

   assign out_valid = !reset && (fifo_count != '0);
   assign out_e     = out_valid ? head : '0;
   assign out_kind  = out_e.kind;
   assign out_pc    = out_e.pc;
   assign out_dest  = out_e.dest;
   assign out_data  = out_e.data;
   assign out_time  = out_e.tstamp;

   assign drop_sum = {1'b0, drop_cnt} + 17'(n_drop);

   always_ff @(posedge clk) begin
      if (reset) begin
         cycle    <= '0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         cycle    <= cycle + 32'd1;
         overflow <= overflow | (n_drop != 2'd0);
         drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
   end

endmodule

// File: tb/tb_trace_collector.sv
// Directed scoreboard bench for trace_collector: stimulus pushes expected
// entries, a negedge monitor pops and compares on each handshake.
module tb_trace_collector;
   import trace_collector_pkg::*;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        w_grf_we;
   logic [4:0]  w_grf_addr;
   logic [31:0] w_grf_wdata, w_inst_addr;
   logic [3:0]  m_data_byteen;
   logic [31:0] m_data_addr, m_data_wdata, m_data_rdata, m_inst_addr;
   logic        out_valid, out_ready, out_kind, overflow;
   logic [31:0] out_pc, out_dest, out_data, out_time;
   logic [15:0] drop_cnt;

   trace_entry_t sb[$];
   int          n_pass = 0;
   int          n_total = 0;
   logic [31:0] tb_time = '0;

   trace_collector #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .w_grf_we(w_grf_we), .w_grf_addr(w_grf_addr), .w_grf_wdata(w_grf_wdata),
      .w_inst_addr(w_inst_addr), .m_data_byteen(m_data_byteen),
      .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
      .m_data_rdata(m_data_rdata), .m_inst_addr(m_inst_addr),
      .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
      .out_pc(out_pc), .out_dest(out_dest), .out_data(out_data),
      .out_time(out_time), .overflow(overflow), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   // Reference cycle counter, used to stamp expected entries
   always @(posedge clk) tb_time <= reset ? 32'd0 : tb_time + 32'd1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         trace_entry_t e;
         n_total++;
         if (sb.size() == 0) begin
            $display("FAIL unexpected_entry: got kind=%0d pc=%h dest=%h data=%h time=%h, expected none",
                     out_kind, out_pc, out_dest, out_data, out_time);
         end else begin
            e = sb.pop_front();
            if (out_kind === e.kind && out_pc === e.pc && out_dest === e.dest &&
                out_data === e.data && out_time === e.tstamp)
               n_pass++;
            else
               $display("FAIL entry: got kind=%0d pc=%h dest=%h data=%h time=%h, expected kind=%0d pc=%h dest=%h data=%h time=%h",
                        out_kind, out_pc, out_dest, out_data, out_time,
                        e.kind, e.pc, e.dest, e.data, e.tstamp);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ev(input logic gwe, input logic [4:0] ga, input logic [31:0] gd,
                         input logic [31:0] gpc, input logic [3:0] be,
                         input logic [31:0] ma, input logic [31:0] mw,
                         input logic [31:0] mr, input logic [31:0] mpc);
      w_grf_we = gwe; w_grf_addr = ga; w_grf_wdata = gd; w_inst_addr = gpc;
      m_data_byteen = be; m_data_addr = ma; m_data_wdata = mw;
      m_data_rdata = mr; m_inst_addr = mpc;
   endtask

   task automatic clear_ev();
      set_ev(1'b0, 5'd0, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
   endtask

   task automatic push(input logic k, input logic [31:0] pc, input logic [31:0] dest,
                       input logic [31:0] data, input logic [31:0] t);
      sb.push_back('{kind: k, pc: pc, dest: dest, data: data, tstamp: t});
   endtask

   task automatic drain(input string name, input int max_cycles);
      for (int i = 0; i < max_cycles && sb.size() != 0; i++) tick();
      chk(name, sb.size(), 0);
   endtask

   initial begin
      reset = 1'b1;
      out_ready = 1'b0;
      clear_ev();
      // Events present during reset must be ignored
      set_ev(1'b1, 5'd7, 32'h77, 32'h1000, 4'hF, 32'h10, 32'h1, 32'h2, 32'h1004);
      tick(); tick(); tick();
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_overflow", {31'd0, overflow}, 32'd0);
      chk("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
      chk("rst_pc", out_pc, 32'd0);
      chk("rst_time", out_time, 32'd0);
      clear_ev();
      reset = 1'b0;

      // Single GRF write, one-cycle latency, no bypass
      out_ready = 1'b1;
      set_ev(1'b1, 5'd5, 32'h12345678, 32'h3004, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
      push(KIND_GRF, 32'h3004, 32'h5, 32'h12345678, tb_time);
      chk("no_bypass", {31'd0, out_valid}, 32'd0);
      tick(); clear_ev();
      chk("grf_latency", {31'd0, out_valid}, 32'd1);
      drain("drain_grf", 5);

      // Byte store merged into the current memory word
      set_ev(1'b0, 5'd0, 32'd0, 32'd0, 4'b0100, 32'h6, 32'h00AB0000, 32'h11223344, 32'h3008);
      push(KIND_MEM, 32'h3008, 32'h4, 32'h11AB3344, tb_time);
      tick(); clear_ev();
      drain("drain_mem", 5);

      // Simultaneous GRF $3 and halfword store: GRF first, same timestamp
      set_ev(1'b1, 5'd3, 32'hCAFE0003, 32'h3010, 4'b0011, 32'h203, 32'h0000BEEF,
             32'h11223344, 32'h300C);
      push(KIND_GRF, 32'h3010, 32'h3, 32'hCAFE0003, tb_time);
      push(KIND_MEM, 32'h300C, 32'h200, 32'h1122BEEF, tb_time);
      tick(); clear_ev();
      chk("dual_first_valid", {31'd0, out_valid}, 32'd1);
      tick();
      chk("dual_second_valid", {31'd0, out_valid}, 32'd1);
      drain("drain_dual", 5);

      // Filtered events: $0 write and empty byte enable
      set_ev(1'b1, 5'd0, 32'hFFFFFFFF, 32'h3020, 4'd0, 32'h40, 32'h1, 32'h2, 32'h301C);
      tick(); clear_ev();
      chk("filter_valid", {31'd0, out_valid}, 32'd0);
      tick();
      chk("filter_valid2", {31'd0, out_valid}, 32'd0);

      // Overflow: fill DEPTH-1, then a dual event drops the store
      out_ready = 1'b0;
      for (int i = 0; i < DEPTH - 1; i++) begin
         set_ev(1'b1, 5'(i + 1), 32'h100 + i, 32'h4000 + 4 * i, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
         push(KIND_GRF, 32'h4000 + 4 * i, 32'(i + 1), 32'h100 + i, tb_time);
         tick();
      end
      chk("pre_ovf_overflow", {31'd0, overflow}, 32'd0);
      set_ev(1'b1, 5'd10, 32'hAAAA0000, 32'h4100, 4'hF, 32'h8, 32'h55555555, 32'd0, 32'h40FC);
      push(KIND_GRF, 32'h4100, 32'hA, 32'hAAAA0000, tb_time);
      tick(); clear_ev();
      chk("ovf_overflow", {31'd0, overflow}, 32'd1);
      chk("ovf_drop_cnt", {16'd0, drop_cnt}, 32'd1);
      // Full FIFO with a dequeue accepts one new event
      out_ready = 1'b1;
      set_ev(1'b1, 5'd11, 32'hBBBB0000, 32'h4104, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
      push(KIND_GRF, 32'h4104, 32'hB, 32'hBBBB0000, tb_time);
      tick(); clear_ev();
      chk("full_deq_drop_cnt", {16'd0, drop_cnt}, 32'd1);
      drain("drain_ovf", 20);
      chk("overflow_sticky", {31'd0, overflow}, 32'd1);

      // Reset mid-stream discards queued entries
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_ev(1'b1, 5'(20 + i), 32'h200 + i, 32'h5000 + 4 * i, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
         tick();
      end
      clear_ev();
      chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_overflow", {31'd0, overflow}, 32'd0);
      chk("mid_rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
      out_ready = 1'b1;
      set_ev(1'b1, 5'd9, 32'h99999999, 32'h6000, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
      push(KIND_GRF, 32'h6000, 32'h9, 32'h99999999, 32'h0);
      tick(); clear_ev();
      chk("post_rst_time", out_time, 32'h0);
      drain("drain_rst", 5);
      tick(); tick();
      chk("final_empty", {31'd0, out_valid}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
